axis_mcdma_arb: RTL
===================

AXIS_MCDMA_ARB -- requirements
Module: axis_mcdma_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 32: tdata width in bits; multiple of 8, else elaboration fatal.
REQ-002 Parameter NUM_CH, default 4: number of slave streams, legal range 1..16, else elaboration fatal.
REQ-003 clk  in  1  clock; every register is rising-edge only.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ch_en  in  NUM_CH  per-channel arbitration enable.
REQ-006 s_tdata  in  NUM_CH*DATA_WIDTH  slave data; channel i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 s_tkeep  in  NUM_CH*DATA_WIDTH/8  slave byte enables, sliced the same way as s_tdata.
REQ-008 s_tlast  in  NUM_CH  per-channel end of packet.
REQ-009 s_tvalid  in  NUM_CH  per-channel valid.
REQ-010 s_tready  out  NUM_CH  per-channel ready.
REQ-011 m_tdata  out  DATA_WIDTH  merged data to the MCDMA S2MM port.
REQ-012 m_tkeep  out  DATA_WIDTH/8  merged byte enables.
REQ-013 m_tdest  out  4  index of the source channel.
REQ-014 m_tlast  out  1  end of packet.
REQ-015 m_tvalid  out  1  master valid.
REQ-016 m_tready  in  1  master ready.
REQ-017 pkt_cnt  out  16  count of packets completed on the master port.
REQ-018 busy  out  1  high whenever the FSM is in XFER.

Function
REQ-019 FSM states: IDLE, XFER.
REQ-020 IDLE -> XFER when any channel i has ch_en[i]=1 and s_tvalid[i]=1; the grant register loads the winner on the same edge.
REQ-021 Arbitration is round-robin: search starts at (last_grant+1) mod NUM_CH and takes the first eligible index; last_grant resets to NUM_CH-1, so channel 0 has first priority.
REQ-022 Grants are packet-granular: in XFER the grant is held until a beat with s_tlast=1 is accepted from the granted channel; that edge returns the FSM to IDLE and sets last_grant to the granted index.
REQ-023 Consequence of REQ-020/REQ-022: exactly one idle cycle separates consecutive packets.
REQ-024 In XFER, s_tready[grant] = m_tready | ~m_tvalid; every other s_tready bit is 0.
REQ-025 In IDLE, all s_tready bits are 0.
REQ-026 The output stage is a single register: on each accepted slave beat, tdata, tkeep, tlast and grant (as tdest) load into the m_* registers and m_tvalid sets to 1.
REQ-027 Latency is 1 cycle from slave handshake to m_tvalid.
REQ-028 Throughput is 1 beat/cycle while m_tready=1.
REQ-029 m_tvalid clears on a master handshake (m_tvalid & m_tready) when no new slave beat is accepted on the same edge.
REQ-030 While m_tvalid=1 and m_tready=0, all m_* outputs hold stable.
REQ-031 m_tdest = grant zero-extended to 4 bits.
REQ-032 Deasserting ch_en[i] mid-packet does not abort the packet: the packet completes and channel i receives no further grant until re-enabled.
REQ-033 A channel with s_tvalid=0 mid-packet stalls the arbiter in XFER; there is no timeout.
REQ-034 pkt_cnt increments by 1 on each master handshake with m_tlast=1, wraps 0xFFFF -> 0x0000, and never saturates.
REQ-035 A single-beat packet (s_tlast on the first beat) is legal and follows REQ-022.

Reset
REQ-036 While rst=1: FSM = IDLE, last_grant = NUM_CH-1, m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, m_tdest=0, pkt_cnt=0, busy=0, s_tready=0.
REQ-037 rst asserted mid-packet discards the packet in flight and any registered output beat; no beat is emitted and no tlast is synthesized.
REQ-038 The first cycle after rst deasserts is in IDLE.

Verification
REQ-039 Single channel: ch_en=0001, ch0 sends 4-beat packet 0xA0..0xA3 with m_tready=1 -> m_tdata A0..A3 on consecutive cycles, tdest=0, m_tlast on A3, pkt_cnt=1.
REQ-040 Round-robin: all channels enabled and continuously valid with 2-beat packets -> m_tdest sequence 0,1,2,3,0; one idle cycle between packets.
REQ-041 Backpressure: m_tready toggles 1,0,1,0 during a ch2 packet -> no beat lost or duplicated, m_* stable while m_tready=0, s_tready[2] low whenever m_tvalid=1 and m_tready=0.
REQ-042 Disable mid-packet: ch1 granted, ch_en[1] cleared after beat 1 of 4 -> all 4 beats delivered with tdest=1, then ch1 never granted while ch0 and ch1 remain valid.
REQ-043 Reset mid-packet: rst pulsed for 1 cycle at beat 2 of 4 -> m_tvalid=0 the next cycle, pkt_cnt=0, next grant goes to ch0.
REQ-044 Counter wrap: 65536 single-beat packets -> pkt_cnt returns to 0x0000.

Source files
------------

// File: rtl/axis_mcdma_arb.sv
`default_nettype none
// ============================================================================
// Module   : axis_mcdma_arb
// Purpose  : Packet-granular round-robin merge of NUM_CH AXI-Stream slaves
//            into one master stream for an MCDMA S2MM port. The source
//            channel index is carried on m_tdest.
// Ports    : clk, rst (synchronous, active-high)
//            ch_en      - per-channel arbitration enable
//            s_t*       - NUM_CH packed slave streams (channel i at slice i)
//            m_t*       - merged master stream, single output register
//            pkt_cnt    - wrapping count of packets completed on the master
//            busy       - high while a packet grant is active
// Revision : 1.0 - initial release
// ============================================================================
module axis_mcdma_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CH-1:0]                   ch_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0]        s_tdata,
    input  logic [NUM_CH*(DATA_WIDTH/8)-1:0]    s_tkeep,
    input  logic [NUM_CH-1:0]                   s_tlast,
    input  logic [NUM_CH-1:0]                   s_tvalid,
    output logic [NUM_CH-1:0]                   s_tready,
    output logic [DATA_WIDTH-1:0]               m_tdata,
    output logic [DATA_WIDTH/8-1:0]             m_tkeep,
    output logic [3:0]                          m_tdest,
    output logic                                m_tlast,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic [15:0]                         pkt_cnt,
    output logic                                busy
);

    localparam int c_gw = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_kw = DATA_WIDTH / 8;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_data_width
        $fatal(1, "axis_mcdma_arb: DATA_WIDTH must be a positive multiple of 8");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $fatal(1, "axis_mcdma_arb: NUM_CH must be in 1..16");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_gw-1:0]     r_grant;
    logic [c_gw-1:0]     r_last_grant;
    logic [c_gw-1:0]     w_winner;
    logic                w_any_elig;
    logic [NUM_CH-1:0]   w_elig;
    logic                w_load_ok;
    logic                w_s_fire;
    logic                w_pkt_end;
    logic                w_m_fire;

    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic [c_kw-1:0]       r_m_tkeep;
    logic [3:0]            r_m_tdest;
    logic                  r_m_tlast;
    logic                  r_m_tvalid;
    logic [15:0]           r_pkt_cnt;

    assign w_elig     = ch_en & s_tvalid;
    assign w_any_elig = |w_elig;

    // Round-robin: scan from the channel after the last completed grant.
    always_comb begin
        int   v_idx;
        logic v_found;
        w_winner = '0;
        v_found  = 1'b0;
        v_idx    = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            v_idx = (int'(r_last_grant) + k) % NUM_CH;
            if (!v_found && w_elig[v_idx]) begin
                v_found  = 1'b1;
                w_winner = c_gw'(v_idx);
            end
        end
    end

    // The output register can take a new beat when empty or draining now.
    assign w_load_ok = m_tready | ~r_m_tvalid;
    assign w_s_fire  = (r_state == ST_XFER) && s_tvalid[r_grant] && w_load_ok;
    assign w_pkt_end = w_s_fire && s_tlast[r_grant];
    assign w_m_fire  = r_m_tvalid & m_tready;

    always_comb begin
        s_tready = '0;
        if (r_state == ST_XFER && w_load_ok) begin
            s_tready[r_grant] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_elig) w_state_nxt = ST_XFER;
            ST_XFER: if (w_pkt_end)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant is captured on the IDLE->XFER edge and held for the whole
    // packet, even if ch_en drops meanwhile.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= c_gw'(NUM_CH - 1);
        end else begin
            if (r_state == ST_IDLE && w_any_elig) begin
                r_grant <= w_winner;
            end
            if (w_pkt_end) begin
                r_last_grant <= r_grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tdest  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tvalid <= 1'b0;
        end else if (w_s_fire) begin
            r_m_tdata  <= s_tdata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
            r_m_tkeep  <= s_tkeep[int'(r_grant)*c_kw +: c_kw];
            r_m_tlast  <= s_tlast[r_grant];
            r_m_tdest  <= 4'(r_grant);
            r_m_tvalid <= 1'b1;
        end else if (w_m_fire) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt <= '0;
        end else if (w_m_fire && r_m_tlast) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    assign m_tdata  = r_m_tdata;
    assign m_tkeep  = r_m_tkeep;
    assign m_tdest  = r_m_tdest;
    assign m_tlast  = r_m_tlast;
    assign m_tvalid = r_m_tvalid;
    assign pkt_cnt  = r_pkt_cnt;
    assign busy     = (r_state == ST_XFER);

endmodule
`default_nettype wire
